sha2_round_funcs: RTL and testbench
===================================

Name: sha2_round_funcs

Overview:
- Registered SHA-2 round-function unit: computes big Sigma0(a), big Sigma1(e), Maj(a,b,c) and Ch(e,f,g) for one compression round.
- Supports SHA-224/256 (32-bit words) and SHA-384/512 (64-bit words), selected per transaction.
- Sits beside the hash-compute unit's working-register file (A..G) and feeds the modular adders that form T1/T2.
- One-cycle pipelined latency with a valid strobe.

Parameters:
- W, 64: datapath width; only 64 is supported.
- S0_32_R1/R2/R3, 2/13/22: Sigma0 rotate amounts in 32-bit mode.
- S1_32_R1/R2/R3, 6/11/25: Sigma1 rotate amounts in 32-bit mode.
- S0_64_R1/R2/R3, 28/34/39: Sigma0 rotate amounts in 64-bit mode.
- S1_64_R1/R2/R3, 14/18/41: Sigma1 rotate amounts in 64-bit mode.

Ports:
- axis_aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid this cycle.
- mode64  in  1  1 = 64-bit word mode (SHA-384/512); 0 = 32-bit word mode (SHA-224/256).
- a_in  in  64  working register A.
- b_in  in  64  working register B.
- c_in  in  64  working register C.
- e_in  in  64  working register E.
- f_in  in  64  working register F.
- g_in  in  64  working register G.
- out_valid  out  1  results valid.
- sigma0_out  out  64  Sigma0(A).
- sigma1_out  out  64  Sigma1(E).
- maj_out  out  64  Maj(A,B,C).
- ch_out  out  64  Ch(E,F,G).

Behaviour:
- Interface: reset reset, synchronous, active-high; clock axis_aclk.
- Reset: out_valid=0 and all data outputs=0 on the first rising edge with reset=1. Reset mid-operation discards the in-flight result.
- Latency: exactly 1 cycle. On each edge, outputs register the functions of the current inputs and out_valid<=in_valid.
- No backpressure: a new operand set is accepted every cycle.
- Data outputs update only when in_valid=1; they hold their value otherwise.
- Word packing in 32-bit mode: the word occupies bits [63:32].
  - Bits [31:0] of every input are ignored.
  - Bits [31:0] of every output are 0.
- Word packing in 64-bit mode: all 64 bits are used.
- Rotation is ROTR within the active word width: 32-bit rotation on [63:32], or 64-bit rotation.
- Sigma0 = ROTR(a,R1) ^ ROTR(a,R2) ^ ROTR(a,R3), using the S0 set for the current mode.
- Sigma1 = the same form applied to e, using the S1 set for the current mode.
- Ch = (e & f) ^ (~e & g).
- Maj = (a & b) ^ (a & c) ^ (b & c).
- Ch and Maj are bitwise and width-independent; the 32-bit-mode masking of [31:0] still applies.
- mode64 is sampled with the operands. Switching mode between consecutive cycles is legal; each result follows the mode captured with its operands.
- No arithmetic carries: purely bitwise logic plus an output register.

Test Plan:
- SHA-256 IV, mode64=0, a=6a09e667, b=bb67ae85, c=3c6ef372, e=510e527f, f=9b05688c, g=1f83d9ab (each in [63:32], junk in [31:0]) -> next cycle:
  - sigma0=ce20b47e_00000000
  - sigma1=3587272b_00000000
  - maj=3a6fe667_00000000
  - ch=1f85c98c_00000000
  - out_valid=1
- Single-bit rotation, mode64=0, a=e=00000001_00000000 -> sigma0=40080400_00000000, sigma1=04200080_00000000.
- Single-bit rotation, mode64=1, a=e=0000000000000001 -> sigma0=0000001042000000, sigma1=0004400000800000.
- Bitwise extremes, mode64=1, a=e=FFFF...F, b=f=0, c=g=AAAA...A -> maj=AAAA...A, ch=0; with e=0 -> ch=g.
- Valid/hold, in_valid pattern 1,0,1 with differing operands -> out_valid is 0,1,0,1 starting from the reset cycle; outputs hold during the bubble; alternating mode64 per beat produces correctly packed results.
- Reset asserted while in_valid=1 -> next cycle out_valid=0 and all outputs 0; the first valid after deassertion produces a correct result one cycle later.

Source files
------------

// File: rtl/sha2_round_funcs.sv
// sha2_round_funcs
// ----------------
// Registered SHA-2 compression-round helper. From one operand set it forms
// big Sigma0(A), big Sigma1(E), Maj(A,B,C) and Ch(E,F,G) in a single cycle.
// This unit sits next to the working-register file and feeds the T1/T2
// adders.
//
// The word size is chosen per transaction:
//   mode64 = 0 : SHA-224/256. The 32-bit word sits in bits [63:32]. Input
//                bits [31:0] are ignored and output bits [31:0] are zero.
//   mode64 = 1 : SHA-384/512. All 64 bits are used.
//
// Ports
//   axis_aclk            clock
//   reset                synchronous, active-high reset
//   in_valid             operand set present this cycle
//   mode64               word-size select, captured with the operands
//   a_in..c_in           working registers A, B, C
//   e_in..g_in           working registers E, F, G
//   out_valid            results valid (one cycle after in_valid)
//   sigma0_out           Sigma0(A)
//   sigma1_out           Sigma1(E)
//   maj_out              Maj(A,B,C)
//   ch_out               Ch(E,F,G)
//
// Data outputs load only on valid beats and hold their value between them.
// The unit never applies backpressure.
module sha2_round_funcs #(
    parameter int W        = 64,   // only 64 is supported
    parameter int S0_32_R1 = 2,
    parameter int S0_32_R2 = 13,
    parameter int S0_32_R3 = 22,
    parameter int S1_32_R1 = 6,
    parameter int S1_32_R2 = 11,
    parameter int S1_32_R3 = 25,
    parameter int S0_64_R1 = 28,
    parameter int S0_64_R2 = 34,
    parameter int S0_64_R3 = 39,
    parameter int S1_64_R1 = 14,
    parameter int S1_64_R2 = 18,
    parameter int S1_64_R3 = 41
) (
    input  logic         axis_aclk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         mode64,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] c_in,
    input  logic [W-1:0] e_in,
    input  logic [W-1:0] f_in,
    input  logic [W-1:0] g_in,
    output logic         out_valid,
    output logic [W-1:0] sigma0_out,
    output logic [W-1:0] sigma1_out,
    output logic [W-1:0] maj_out,
    output logic [W-1:0] ch_out
);

    localparam int HW = W / 2;

    // Rotate right by a constant amount. The word is doubled and then
    // shifted, so the low half of the result holds the rotated word.
    function automatic logic [31:0] rotr32(input logic [31:0] x, input int r);
        logic [63:0] d;
        d = {x, x} >> r;
        return d[31:0];
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int r);
        logic [127:0] d;
        d = {x, x} >> r;
        return d[63:0];
    endfunction

    // ------------------------------------------------------------------
    // Sigma functions for both word sizes, evaluated in parallel
    // ------------------------------------------------------------------
    logic [HW-1:0] a_hi;
    logic [HW-1:0] e_hi;
    logic [HW-1:0] s0_32;
    logic [HW-1:0] s1_32;
    logic [W-1:0]  s0_64;
    logic [W-1:0]  s1_64;

    assign a_hi  = a_in[W-1:HW];
    assign e_hi  = e_in[W-1:HW];

    assign s0_32 = rotr32(a_hi, S0_32_R1) ^ rotr32(a_hi, S0_32_R2) ^ rotr32(a_hi, S0_32_R3);
    assign s1_32 = rotr32(e_hi, S1_32_R1) ^ rotr32(e_hi, S1_32_R2) ^ rotr32(e_hi, S1_32_R3);
    assign s0_64 = rotr64(a_in, S0_64_R1) ^ rotr64(a_in, S0_64_R2) ^ rotr64(a_in, S0_64_R3);
    assign s1_64 = rotr64(e_in, S1_64_R1) ^ rotr64(e_in, S1_64_R2) ^ rotr64(e_in, S1_64_R3);

    // ------------------------------------------------------------------
    // Ch / Maj, one bit per slice. In 32-bit mode the low half is forced
    // to zero, so junk in the unused input bits never reaches the adders.
    // ------------------------------------------------------------------
    logic [W-1:0] ch_bits;
    logic [W-1:0] maj_bits;
    logic [W-1:0] lane_en;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi >= HW) begin : g_hi
                assign lane_en[gi] = 1'b1;
            end else begin : g_lo
                assign lane_en[gi] = mode64;
            end
            assign ch_bits[gi]  = lane_en[gi] &
                                  ((e_in[gi] & f_in[gi]) ^ (~e_in[gi] & g_in[gi]));
            assign maj_bits[gi] = lane_en[gi] &
                                  ((a_in[gi] & b_in[gi]) ^ (a_in[gi] & c_in[gi]) ^
                                   (b_in[gi] & c_in[gi]));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic         valid_reg;
    logic [W-1:0] sigma0_reg, sigma0_next;
    logic [W-1:0] sigma1_reg, sigma1_next;
    logic [W-1:0] maj_reg,    maj_next;
    logic [W-1:0] ch_reg,     ch_next;

    always_comb begin
        sigma0_next = sigma0_reg;
        sigma1_next = sigma1_reg;
        maj_next    = maj_reg;
        ch_next     = ch_reg;
        if (in_valid) begin
            if (mode64) begin
                sigma0_next = s0_64;
                sigma1_next = s1_64;
            end else begin
                sigma0_next = {s0_32, {HW{1'b0}}};
                sigma1_next = {s1_32, {HW{1'b0}}};
            end
            maj_next = maj_bits;
            ch_next  = ch_bits;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            valid_reg  <= 1'b0;
            sigma0_reg <= '0;
            sigma1_reg <= '0;
            maj_reg    <= '0;
            ch_reg     <= '0;
        end else begin
            valid_reg  <= in_valid;
            sigma0_reg <= sigma0_next;
            sigma1_reg <= sigma1_next;
            maj_reg    <= maj_next;
            ch_reg     <= ch_next;
        end
    end

    assign out_valid  = valid_reg;
    assign sigma0_out = sigma0_reg;
    assign sigma1_out = sigma1_reg;
    assign maj_out    = maj_reg;
    assign ch_out     = ch_reg;

endmodule

// File: tb/tb_sha2_round_funcs.sv
// Testbench for sha2_round_funcs. It applies a directed vector table.
// The stimulus pushes each edge's expected response into a scoreboard
// queue. The monitor pops one entry on every following falling edge and
// compares it.
module tb_sha2_round_funcs;

    logic        axis_aclk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        mode64;
    logic [63:0] a_in, b_in, c_in, e_in, f_in, g_in;
    logic        out_valid;
    logic [63:0] sigma0_out, sigma1_out, maj_out, ch_out;

    always #5 axis_aclk = ~axis_aclk;

    sha2_round_funcs dut (
        .axis_aclk  (axis_aclk),
        .reset      (reset),
        .in_valid   (in_valid),
        .mode64     (mode64),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .e_in       (e_in),
        .f_in       (f_in),
        .g_in       (g_in),
        .out_valid  (out_valid),
        .sigma0_out (sigma0_out),
        .sigma1_out (sigma1_out),
        .maj_out    (maj_out),
        .ch_out     (ch_out)
    );

    typedef struct {
        int          id;
        logic        v;
        logic [63:0] s0, s1, mj, ch;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          beat_id = 0;
    logic [63:0] hold_s0 = '0, hold_s1 = '0, hold_mj = '0, hold_ch = '0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALTA = 64'hAAAA_AAAA_AAAA_AAAA;

    // Drive one cycle of stimulus. Expected data follows the hold rule:
    // reset clears it, a valid beat loads it, and a bubble keeps it.
    task automatic beat(input logic rst, input logic vld, input logic m64,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] e, input logic [63:0] f, input logic [63:0] g,
                        input logic [63:0] xs0, input logic [63:0] xs1,
                        input logic [63:0] xmj, input logic [63:0] xch);
        exp_t x;
        reset    = rst;
        in_valid = vld;
        mode64   = m64;
        a_in = a; b_in = b; c_in = c; e_in = e; f_in = f; g_in = g;
        @(posedge axis_aclk);
        if (rst) begin
            hold_s0 = '0; hold_s1 = '0; hold_mj = '0; hold_ch = '0;
        end else if (vld) begin
            hold_s0 = xs0; hold_s1 = xs1; hold_mj = xmj; hold_ch = xch;
        end
        x.id = beat_id;
        x.v  = vld & ~rst;
        x.s0 = hold_s0; x.s1 = hold_s1; x.mj = hold_mj; x.ch = hold_ch;
        sb_q.push_back(x);
        beat_id++;
        #1;
    endtask

    task automatic chk(input int id, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL beat %0d %s: got %h, expected %h", id, name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per clock edge and compares it.
    initial begin
        exp_t x;
        forever begin
            @(negedge axis_aclk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                n_vectors++;
                chk(x.id, "out_valid", {63'd0, out_valid}, {63'd0, x.v});
                chk(x.id, "sigma0", sigma0_out, x.s0);
                chk(x.id, "sigma1", sigma1_out, x.s1);
                chk(x.id, "maj",    maj_out,    x.mj);
                chk(x.id, "ch",     ch_out,     x.ch);
                $display("beat %0d: v=%0b s0=%h s1=%h maj=%h ch=%h",
                         x.id, out_valid, sigma0_out, sigma1_out, maj_out, ch_out);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // 0: reset cycle; inputs look valid but reset wins
        beat(1, 0, 0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        // 1: SHA-256 IV, 32-bit mode, junk in the low halves
        beat(0, 1, 0,
             64'h6a09e667_deadbeef, 64'hbb67ae85_12345678, 64'h3c6ef372_cafef00d,
             64'h510e527f_0badf00d, 64'h9b05688c_ffffffff, 64'h1f83d9ab_a5a5a5a5,
             64'hce20b47e_00000000, 64'h3587272b_00000000,
             64'h3a6fe667_00000000, 64'h1f85c98c_00000000);
        // 2: bubble with different operands; the outputs must hold
        beat(0, 0, 1, ALL1, ALTA, ALL1, ALL1, ALTA, ALL1, '0, '0, '0, '0);
        // 3: single-bit rotation, 64-bit mode
        beat(0, 1, 1, 64'h1, '0, '0, 64'h1, '0, '0,
             64'h0000001042000000, 64'h0004400000800000, '0, '0);
        // 4: single-bit rotation, 32-bit mode (the mode switches back)
        beat(0, 1, 0,
             64'h00000001_ffffffff, 64'h00000000_ffffffff, 64'h00000000_ffffffff,
             64'h00000001_ffffffff, 64'h00000000_ffffffff, 64'h00000000_ffffffff,
             64'h40080400_00000000, 64'h04200080_00000000, '0, '0);
        // 5: bitwise extremes, 64-bit mode
        beat(0, 1, 1, ALL1, '0, ALTA, ALL1, '0, ALTA, ALL1, ALL1, ALTA, '0);
        // 6: with e = 0, Ch selects g
        beat(0, 1, 1, ALL1, '0, ALTA, '0, '0, ALTA, ALL1, '0, ALTA, ALTA);
        // 7: the same extremes in 32-bit mode; the low halves are masked
        beat(0, 1, 0, ALL1, '0, ALTA, ALL1, '0, ALTA,
             64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000,
             64'hAAAAAAAA_00000000, 64'h0);
        // 8: reset while in_valid is high; the beat is discarded
        beat(1, 1, 0,
             64'h6a09e667_00000000, 64'hbb67ae85_00000000, 64'h3c6ef372_00000000,
             64'h510e527f_00000000, 64'h9b05688c_00000000, 64'h1f83d9ab_00000000,
             '0, '0, '0, '0);
        // 9: first valid beat after reset
        beat(0, 1, 0,
             64'h6a09e667_00000000, 64'hbb67ae85_00000000, 64'h3c6ef372_00000000,
             64'h510e527f_00000000, 64'h9b05688c_00000000, 64'h1f83d9ab_00000000,
             64'hce20b47e_00000000, 64'h3587272b_00000000,
             64'h3a6fe667_00000000, 64'h1f85c98c_00000000);
        // 10: idle; the result holds
        beat(0, 0, 0, ALL1, ALL1, ALL1, ALL1, ALL1, ALL1, '0, '0, '0, '0);

        @(negedge axis_aclk);
        @(negedge axis_aclk);
        if (sb_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        if (n_vectors != beat_id) begin
            n_miscompares++;
            $display("FAIL vector_count: checked %0d, expected %0d", n_vectors, beat_id);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
